snake_dir_ctrl: RTL and testbench

//  Input-side producer for the snake mover: conditions the four direction push-buttons
//  (sync, debounce, press-edge detect), rejects illegal turns and delivers the heading.
//  One press is committed per snake step, on move_tick from the mover's step clock.

---
 rtl/snake_dir_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_snake_dir_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/snake_dir_ctrl.sv
// snake_dir_ctrl
//
// Conditions the four direction buttons and delivers the snake heading. Each button is
// synchronised, debounced and edge-detected. Press events that would keep the current
// heading or reverse it are rejected. The last legal press is held as a pending request,
// and that request is committed on the next move_tick.
//
// Heading code: 2'b00 left, 2'b01 down, 2'b10 up, 2'b11 right.
// direction[] is the one-hot of the same heading: [0] left, [1] down, [2] up, [3] right.
//
// Parameters
//   DEBOUNCE_CYCLES  consecutive cycles a synced level must hold before it is accepted
//   BTN_ACTIVE_LOW   1: pad reads 0 when pressed; 0: pad reads 1 when pressed
//
// Ports
//   clk          in   1  system clock
//   clear        in   1  synchronous active-high reset
//   btn          in   4  raw asynchronous buttons: [0] left, [1] down, [2] up, [3] right
//   move_tick    in   1  one-cycle pulse per snake step
//   direction    out  4  one-hot committed heading (registered)
//   moveway      out  2  encoded committed heading (registered)
//   dir_pending  out  1  a legal request waits for the next move_tick
//   dir_change   out  1  pulse in the cycle after a commit

module snake_dir_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 10000,
    parameter bit          BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic       clk,
    input  logic       clear,
    input  logic [3:0] btn,
    input  logic       move_tick,
    output logic [3:0] direction,
    output logic [1:0] moveway,
    output logic       dir_pending,
    output logic       dir_change
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    // Raw pad level of a released button.
    localparam logic [3:0] PadReleased = {4{BTN_ACTIVE_LOW}};

    localparam logic [1:0] HeadLeft  = 2'b00;
    localparam logic [1:0] HeadDown  = 2'b01;
    localparam logic [1:0] HeadUp    = 2'b10;
    localparam logic [1:0] HeadRight = 2'b11;

    // Button bit positions.
    localparam int unsigned BitLeft  = 0;
    localparam int unsigned BitDown  = 1;
    localparam int unsigned BitUp    = 2;
    localparam int unsigned BitRight = 3;

    function automatic logic [3:0] head_onehot(input logic [1:0] head);
        logic [3:0] oh;
        oh       = 4'b0000;
        oh[head] = 1'b1;
        return oh;
    endfunction

    // ------------------------------------------------------------------
    // Two-flop synchroniser on the raw pads
    // ------------------------------------------------------------------
    logic [3:0] sync1_q, sync1_d;
    logic [3:0] sync2_q, sync2_d;
    logic [3:0] synced;

    always_comb begin
        sync1_d = btn;
        sync2_d = sync1_q;
    end

    // Normalise to active-high: 1 means pressed from here on.
    assign synced = BTN_ACTIVE_LOW ? ~sync2_q : sync2_q;

    // ------------------------------------------------------------------
    // Per-bit debounce
    // ------------------------------------------------------------------
    logic [3:0]      stable_q, stable_d;
    logic [CntW-1:0] cnt_q [4];
    logic [CntW-1:0] cnt_d [4];
    logic [3:0]      press;

    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = cnt_q[i];
            if (synced[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CntMax) begin
                stable_d[i] = synced[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    // The rising edge is taken from the next-state level, so the press event is acted on
    // in the same edge that updates the stable level (no extra edge-flop latency).
    assign press = stable_d & ~stable_q;

    // ------------------------------------------------------------------
    // Same-cycle arbitration: right > left > down > up
    // ------------------------------------------------------------------
    logic       ev_valid;
    logic [1:0] ev_head;

    always_comb begin
        ev_valid = 1'b1;
        ev_head  = HeadRight;
        if (press[BitRight]) begin
            ev_head = HeadRight;
        end else if (press[BitLeft]) begin
            ev_head = HeadLeft;
        end else if (press[BitDown]) begin
            ev_head = HeadDown;
        end else if (press[BitUp]) begin
            ev_head = HeadUp;
        end else begin
            ev_valid = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Turn legality and commit
    // ------------------------------------------------------------------
    logic [1:0] moveway_q, moveway_d;
    logic [3:0] direction_q, direction_d;
    logic [1:0] pending_dir_q, pending_dir_d;
    logic       dir_pending_q, dir_pending_d;
    logic       dir_change_q, dir_change_d;

    logic       commit;
    logic [1:0] ref_head;
    logic       ev_legal;

    assign commit = move_tick & dir_pending_q;

    // Legality is judged against the heading that holds after this edge, so a press that
    // lands on the commit cycle cannot reverse the request being committed.
    assign ref_head = commit ? pending_dir_q : moveway_q;

    // The code is chosen so that reversing a heading is bitwise inversion.
    assign ev_legal = ev_valid && (ev_head != ref_head) && (ev_head != ~ref_head);

    always_comb begin
        moveway_d     = moveway_q;
        pending_dir_d = pending_dir_q;
        dir_pending_d = dir_pending_q;
        dir_change_d  = 1'b0;

        if (commit) begin
            moveway_d     = pending_dir_q;
            dir_pending_d = 1'b0;
            dir_change_d  = 1'b1;
        end

        // Last legal press wins, including one arriving on the commit cycle.
        if (ev_legal) begin
            pending_dir_d = ev_head;
            dir_pending_d = 1'b1;
        end

        direction_d = head_onehot(moveway_d);
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (clear) begin
            sync1_q       <= PadReleased;
            sync2_q       <= PadReleased;
            stable_q      <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
            moveway_q     <= HeadRight;
            direction_q   <= 4'b1000;
            pending_dir_q <= HeadRight;
            dir_pending_q <= 1'b0;
            dir_change_q  <= 1'b0;
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            stable_q      <= stable_d;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            moveway_q     <= moveway_d;
            direction_q   <= direction_d;
            pending_dir_q <= pending_dir_d;
            dir_pending_q <= dir_pending_d;
            dir_change_q  <= dir_change_d;
        end
    end

    assign moveway     = moveway_q;
    assign direction   = direction_q;
    assign dir_pending = dir_pending_q;
    assign dir_change  = dir_change_q;

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// Bench for snake_dir_ctrl with DEBOUNCE_CYCLES=4, active-low pads. A reference model
// predicts the outputs after each clock edge and queues them; a monitor pops and
// compares one entry per edge.

module tb_snake_dir_ctrl;

    localparam int unsigned D = 4;

    logic       clk = 1'b0;
    logic       clear = 1'b0;
    logic [3:0] btn = 4'hF;
    logic       move_tick = 1'b0;
    logic [3:0] direction;
    logic [1:0] moveway;
    logic       dir_pending;
    logic       dir_change;

    always #5 clk = ~clk;

    snake_dir_ctrl #(
        .DEBOUNCE_CYCLES(D),
        .BTN_ACTIVE_LOW (1'b1)
    ) dut (
        .clk        (clk),
        .clear      (clear),
        .btn        (btn),
        .move_tick  (move_tick),
        .direction  (direction),
        .moveway    (moveway),
        .dir_pending(dir_pending),
        .dir_change (dir_change)
    );

    typedef struct packed {
        logic [1:0] mw;
        logic [3:0] dir;
        logic       pend;
        logic       chg;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // ---------------- reference model ----------------
    logic [1:0] m_head, m_pdir;
    logic       m_pend, m_chg;
    logic [3:0] m_stable;
    logic [3:0] pad_hist[$];  // pressed levels seen at recent edges, oldest first
    logic [3:0] syn_hist[$];  // last D synchronised levels, oldest first

    task automatic model_step(input logic [3:0] pressed, input bit tick, input bit clr);
        logic [3:0] synced, old_stable, rise;
        logic [1:0] ref_h, ev;
        bit         ev_ok, all_diff;
        int         order[4];
        order = '{3, 0, 1, 2};
        if (clr) begin
            m_head   = 2'd3;
            m_pdir   = 2'd3;
            m_pend   = 1'b0;
            m_chg    = 1'b0;
            m_stable = 4'b0000;
            pad_hist = '{4'b0000, 4'b0000};
            syn_hist = '{};
        end else begin
            // The level used for debouncing is the pad as it was two edges earlier.
            pad_hist.push_back(pressed);
            synced = pad_hist[0];
            pad_hist.pop_front();
            syn_hist.push_back(synced);
            if (syn_hist.size() > D) void'(syn_hist.pop_front());
            old_stable = m_stable;
            // A level is accepted once it has differed from the stable one for D edges.
            for (int b = 0; b < 4; b++) begin
                all_diff = (syn_hist.size() == D);
                foreach (syn_hist[k]) if (syn_hist[k][b] == m_stable[b]) all_diff = 0;
                if (all_diff) m_stable[b] = ~m_stable[b];
            end
            rise  = m_stable & ~old_stable;
            ev_ok = 0;
            ev    = 2'd0;
            for (int k = 0; k < 4; k++) begin
                if (!ev_ok && rise[order[k]]) begin
                    ev_ok = 1;
                    ev    = 2'(order[k]);  // button bit index equals heading code
                end
            end
            ref_h = (tick && m_pend) ? m_pdir : m_head;
            if (tick && m_pend) begin
                m_head = m_pdir;
                m_pend = 1'b0;
                m_chg  = 1'b1;
            end else begin
                m_chg = 1'b0;
            end
            if (ev_ok && ev != ref_h && ev != 2'd3 - ref_h) begin
                m_pdir = ev;
                m_pend = 1'b1;
            end
        end
    endtask

    // Drive one cycle of stimulus (pressed is active-high) and queue the prediction.
    task automatic cyc(input logic [3:0] pressed, input bit tick, input bit clr);
        exp_t e;
        @(negedge clk);
        btn       = ~pressed;
        move_tick = tick;
        clear     = clr;
        model_step(pressed, tick, clr);
        e.mw   = m_head;
        e.dir  = 4'b0001 << m_head;
        e.pend = m_pend;
        e.chg  = m_chg;
        exp_q.push_back(e);
    endtask

    task automatic hold(input logic [3:0] pressed, input int n);
        repeat (n) cyc(pressed, 1'b0, 1'b0);
    endtask

    // ---------------- monitor ----------------
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (moveway !== e.mw || direction !== e.dir || dir_pending !== e.pend ||
                dir_change !== e.chg) begin
                miscompares++;
                $display("FAIL outputs t=%0t got mw=%b dir=%b pend=%b chg=%b want mw=%b dir=%b pend=%b chg=%b",
                         $time, moveway, direction, dir_pending, dir_change,
                         e.mw, e.dir, e.pend, e.chg);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [3:0] p;

        // 1: reset with all pads released
        cyc(4'b0000, 1'b0, 1'b1);
        hold(4'b0000, 3);

        // 2: up with 3-cycle glitches, then a clean hold and a tick
        repeat (2) begin
            hold(4'b0100, 3);
            hold(4'b0000, 3);
        end
        hold(4'b0100, 8);
        cyc(4'b0100, 1'b1, 1'b0);
        hold(4'b0100, 2);
        hold(4'b0000, 8);

        // 4: left and down in the same cycle while heading up
        hold(4'b0011, 8);
        cyc(4'b0011, 1'b1, 1'b0);
        hold(4'b0000, 8);

        // 3: reversal rejected, then down overwritten by up
        cyc(4'b0000, 1'b0, 1'b1);
        hold(4'b0001, 8);
        hold(4'b0000, 8);
        hold(4'b0010, 8);
        hold(4'b0110, 8);
        cyc(4'b0110, 1'b1, 1'b0);
        hold(4'b0000, 8);

        // 5: pending up, down debounces on the tick cycle
        cyc(4'b0000, 1'b0, 1'b1);
        hold(4'b0100, 8);
        hold(4'b0000, 8);
        hold(4'b0010, 5);
        cyc(4'b0010, 1'b1, 1'b0);
        hold(4'b0010, 2);
        hold(4'b0000, 8);

        // 6: clear on the tick cycle with down pending
        cyc(4'b0000, 1'b0, 1'b1);
        hold(4'b0010, 8);
        cyc(4'b0010, 1'b1, 1'b1);
        hold(4'b0000, 8);

        // Random phase: slowly toggling buttons with glitches, random ticks and clears
        p = 4'b0000;
        repeat (3000) begin
            if ($urandom_range(7) == 0) p[$urandom_range(3)] ^= 1'b1;
            cyc(p, ($urandom_range(5) == 0), ($urandom_range(499) == 0));
        end

        // Let the monitor drain the last prediction.
        @(posedge clk);
        @(posedge clk);
        #2;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain left=%0d required=0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
